// File: rtl/fifo_mc_clearable_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mc_clearable_pkg
// Purpose  : Shared types and helpers for the multi-channel clearable FIFO.
//            Holds the per-channel clear-sequence state encoding and the
//            level-width helper used to size fill-level ports.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_mc_clearable_pkg;

  // Per-channel clear sequencing: IDLE -> ISOLATE -> CLEAR -> IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    CLEAR   = 2'd2
  } clr_state_e;

  // Level counts storage entries plus the output register, so it needs one
  // bit more than the address to represent Depth+1.
  function automatic int unsigned level_width(input int unsigned log_depth);
    return log_depth + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mc_clearable_chan.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mc_clearable_chan
// Purpose  : One FIFO channel: 2**LogDepth storage entries, binary pointers,
//            registered output stage and an isolate-then-clear sequencer.
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            clear_i                clear request (pulse or level)
//            clear_pending_o        channel is inside its clear sequence
//            src_data_i/valid/ready write side
//            dst_data_o/valid/ready read side (registered data)
//            level_o                storage count + output register valid
//            almost_full_o          level_o >= AlmostFullThr
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mc_clearable_chan
  import fifo_mc_clearable_pkg::*;
#(
  parameter int unsigned LogDepth      = 3,
  parameter int unsigned AlmostFullThr = 7,
  parameter type         T             = logic [31:0],
  localparam int unsigned Lw           = level_width(LogDepth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  output logic          clear_pending_o,
  input  T              src_data_i,
  input  logic          src_valid_i,
  output logic          src_ready_o,
  output T              dst_data_o,
  output logic          dst_valid_o,
  input  logic          dst_ready_i,
  output logic [Lw-1:0] level_o,
  output logic          almost_full_o
);

  localparam int unsigned   Depth   = 2**LogDepth;
  localparam logic [Lw-1:0] ThrQ    = Lw'(AlmostFullThr);
  // Full when the addresses match but the wrap bits differ.
  localparam logic [Lw-1:0] FullXor = {1'b1, {LogDepth{1'b0}}};

  T                mem_q [Depth];
  T                out_data_q;
  logic [Lw-1:0]   wptr_q, wptr_d;
  logic [Lw-1:0]   rptr_q, rptr_d;
  logic            out_valid_q, out_valid_d;
  clr_state_e      state_q, state_d;

  logic            idle, clr_now;
  logic            empty, full, wr_en, rd_pop, load;

  // ---------------- clear FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- clear FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_i) state_d = ISOLATE;
      ISOLATE: state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- clear FSM: outputs ----------------
  always_comb begin
    idle    = (state_q == IDLE);
    clr_now = (state_q == CLEAR);
  end

  assign clear_pending_o = ~idle;

  // ---------------- handshakes ----------------
  assign empty       = (wptr_q == rptr_q);
  assign full        = ((wptr_q ^ rptr_q) == FullXor);
  assign src_ready_o = ~full & idle;
  assign dst_valid_o = out_valid_q & idle;
  assign wr_en       = src_valid_i & src_ready_o;
  assign rd_pop      = dst_valid_o & dst_ready_i;
  // Refill is gated by idle so the isolate/clear cycles leave storage alone.
  assign load        = idle & ~empty & (~out_valid_q | rd_pop);

  // ---------------- pointer / valid next state ----------------
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    if (clr_now) begin
      wptr_d      = '0;
      rptr_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + Lw'(1);
      if (load) begin
        rptr_d      = rptr_q + Lw'(1);
        out_valid_d = 1'b1;
      end else if (rd_pop) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload storage carries no reset; only control state is initialised.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[LogDepth-1:0]] <= src_data_i;
    if (load)  out_data_q <= mem_q[rptr_q[LogDepth-1:0]];
  end

  assign dst_data_o    = out_data_q;
  assign level_o       = (wptr_q - rptr_q) + Lw'(out_valid_q);
  assign almost_full_o = (level_o >= ThrQ);

endmodule
`default_nettype wire

// File: rtl/fifo_mc_clearable.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mc_clearable
// Purpose  : Bank of NumChan independent single-clock FIFOs, each with its
//            own warm-clear sequencing, fill level and almost-full flag.
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            clear_i[NumChan]       per-channel clear request
//            clear_pending_o        per-channel clear in progress
//            src_*                  flat-packed write side, channel c at
//                                   slice [c*W +: W]
//            dst_*                  flat-packed read side
//            level_o                per-channel level, LogDepth+1 bits each
//            almost_full_o          per-channel level >= AlmostFullThr
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mc_clearable
  import fifo_mc_clearable_pkg::*;
#(
  parameter int unsigned NumChan       = 4,
  parameter int unsigned Width         = 32,
  parameter int unsigned LogDepth      = 3,
  parameter int unsigned AlmostFullThr = 2**LogDepth - 1,
  parameter type         T             = logic [Width-1:0]
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumChan-1:0]                      clear_i,
  output logic [NumChan-1:0]                      clear_pending_o,
  input  logic [NumChan*$bits(T)-1:0]             src_data_i,
  input  logic [NumChan-1:0]                      src_valid_i,
  output logic [NumChan-1:0]                      src_ready_o,
  output logic [NumChan*$bits(T)-1:0]             dst_data_o,
  output logic [NumChan-1:0]                      dst_valid_o,
  input  logic [NumChan-1:0]                      dst_ready_i,
  output logic [NumChan*level_width(LogDepth)-1:0] level_o,
  output logic [NumChan-1:0]                      almost_full_o
);

  localparam int unsigned Lw = level_width(LogDepth);
  localparam int unsigned Tw = $bits(T);

  // Parameter sanity checks at elaboration.
  if (LogDepth < 1) begin : g_chk_logdepth
    $error("fifo_mc_clearable: LogDepth must be >= 1");
  end
  if (NumChan < 1) begin : g_chk_numchan
    $error("fifo_mc_clearable: NumChan must be >= 1");
  end
  if ((AlmostFullThr < 1) || (AlmostFullThr > 2**LogDepth + 1)) begin : g_chk_thr
    $error("fifo_mc_clearable: AlmostFullThr must be in 1..Depth+1");
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    T src_data;
    T dst_data;

    assign src_data                = T'(src_data_i[c*Tw +: Tw]);
    assign dst_data_o[c*Tw +: Tw]  = dst_data;

    fifo_mc_clearable_chan #(
      .LogDepth      (LogDepth),
      .AlmostFullThr (AlmostFullThr),
      .T             (T)
    ) u_chan (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clear_i         (clear_i[c]),
      .clear_pending_o (clear_pending_o[c]),
      .src_data_i      (src_data),
      .src_valid_i     (src_valid_i[c]),
      .src_ready_o     (src_ready_o[c]),
      .dst_data_o      (dst_data),
      .dst_valid_o     (dst_valid_o[c]),
      .dst_ready_i     (dst_ready_i[c]),
      .level_o         (level_o[c*Lw +: Lw]),
      .almost_full_o   (almost_full_o[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_mc_clearable.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_mc_clearable
// Purpose  : Directed testbench for fifo_mc_clearable (4 channels, 32-bit,
//            depth 8). Accepted writes feed per-channel expectation queues;
//            a monitor compares every read handshake against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_mc_clearable;

  localparam int NC = 4;
  localparam int W  = 32;
  localparam int LD = 3;
  localparam int LW = LD + 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NC-1:0]     clear_i;
  logic [NC-1:0]     clear_pending_o;
  logic [NC*W-1:0]   src_data_i;
  logic [NC-1:0]     src_valid_i;
  logic [NC-1:0]     src_ready_o;
  logic [NC*W-1:0]   dst_data_o;
  logic [NC-1:0]     dst_valid_o;
  logic [NC-1:0]     dst_ready_i;
  logic [NC*LW-1:0]  level_o;
  logic [NC-1:0]     almost_full_o;

  fifo_mc_clearable #(
    .NumChan       (NC),
    .Width         (W),
    .LogDepth      (LD),
    .AlmostFullThr (7)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .clear_pending_o (clear_pending_o),
    .src_data_i      (src_data_i),
    .src_valid_i     (src_valid_i),
    .src_ready_o     (src_ready_o),
    .dst_data_o      (dst_data_o),
    .dst_valid_o     (dst_valid_o),
    .dst_ready_i     (dst_ready_i),
    .level_o         (level_o),
    .almost_full_o   (almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [NC][$];
  int rd_cnt [NC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LW-1:0] lvl(input int c);
    return level_o[c*LW +: LW];
  endfunction

  task automatic put(input int c, input logic v, input logic [W-1:0] d);
    src_valid_i[c]        = v;
    src_data_i[c*W +: W]  = d;
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int c = 0; c < NC; c++) begin
        if (dst_valid_o[c] && dst_ready_i[c]) begin
          checks++;
          rd_cnt[c]++;
          if (exp_q[c].size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected ch%0d: got %0h expected none", c, dst_data_o[c*W +: W]);
          end else begin
            logic [W-1:0] e;
            e = exp_q[c].pop_front();
            if (dst_data_o[c*W +: W] !== e) begin
              errors++;
              $display("FAIL rd_data ch%0d: got %0h expected %0h", c, dst_data_o[c*W +: W], e);
            end
          end
        end
        if (src_valid_i[c] && src_ready_o[c]) exp_q[c].push_back(src_data_i[c*W +: W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit exp_pend [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int gaps;

  initial begin
    for (int c = 0; c < NC; c++) rd_cnt[c] = 0;
    rst_ni = 1'b0; clear_i = '0; src_data_i = '0; src_valid_i = '0; dst_ready_i = '0;
    repeat (2) cyc();

    // ---- reset state ----
    chk("rst_src_ready", src_ready_o, 4'hF);
    chk("rst_dst_valid", dst_valid_o, 4'h0);
    chk("rst_level", level_o, 16'h0);
    chk("rst_af", almost_full_o, 4'h0);
    chk("rst_pending", clear_pending_o, 4'h0);
    rst_ni = 1'b1;
    cyc();

    // ---- fill ch0 with reader stalled ----
    for (int i = 0; i < 8; i++) begin
      put(0, 1'b1, 32'hA0 + i);
      cyc();
      chk("fill_level", lvl(0), i + 1);
      chk("fill_af", almost_full_o[0], (i + 1) >= 7);
    end
    chk("fill8_ready", src_ready_o[0], 1'b1);
    put(0, 1'b1, 32'hA8);
    cyc();
    chk("fill9_level", lvl(0), 9);
    chk("fill9_ready", src_ready_o[0], 1'b0);
    put(0, 1'b1, 32'hA9);                 // refused: storage full
    cyc();
    chk("fill10_level", lvl(0), 9);
    chk("fill10_ready", src_ready_o[0], 1'b0);
    put(0, 1'b0, 32'h0);
    dst_ready_i[0] = 1'b1;
    cyc();
    chk("unfull_ready", src_ready_o[0], 1'b1);
    chk("unfull_level", lvl(0), 8);
    repeat (12) cyc();
    chk("drain0_level", lvl(0), 0);
    chk("drain0_count", rd_cnt[0], 9);
    dst_ready_i[0] = 1'b0;

    // ---- streaming on ch1 ----
    dst_ready_i[1] = 1'b1;
    gaps = 0;
    for (int i = 0; i < 100; i++) begin
      put(1, 1'b1, 32'h100 + i);
      if (i < 2) chk("stream_latency", dst_valid_o[1], 1'b0);
      else if (!dst_valid_o[1]) gaps++;
      cyc();
    end
    put(1, 1'b0, 32'h0);
    repeat (4) cyc();
    chk("stream_gaps", gaps, 0);
    chk("stream_count", rd_cnt[1], 100);

    // ---- clear ch2 with concurrent handshakes ----
    dst_ready_i[2] = 1'b0; dst_ready_i[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(2, 1'b1, 32'hB0 + i);
      put(3, i < 2, 32'hC0 + i);
      cyc();
    end
    put(3, 1'b0, 32'h0);
    chk("pre_clr_level2", lvl(2), 5);
    chk("pre_clr_level3", lvl(3), 2);
    clear_i[2] = 1'b1; put(2, 1'b1, 32'hB5); dst_ready_i[2] = 1'b1;   // cycle n
    cyc();                                                          // n+1
    clear_i[2] = 1'b0; put(2, 1'b0, 32'h0);
    exp_q[2].delete();
    chk("clr_rd_done", rd_cnt[2], 1);
    chk("clr_pend_n1", clear_pending_o[2], 1'b1);
    chk("clr_iso_ready", src_ready_o[2], 1'b0);
    chk("clr_iso_valid", dst_valid_o[2], 1'b0);
    chk("clr_other_pend", clear_pending_o[3], 1'b0);
    cyc();                                                          // n+2
    chk("clr_pend_n2", clear_pending_o[2], 1'b1);
    cyc();                                                          // n+3
    chk("clr_pend_n3", clear_pending_o[2], 1'b0);
    chk("clr_level_n3", lvl(2), 0);
    chk("clr_ready_n3", src_ready_o[2], 1'b1);
    repeat (4) cyc();
    chk("clr_no_stale", dst_valid_o[2], 1'b0);
    chk("clr_ch3_level", lvl(3), 2);
    chk("clr_ch0_level", lvl(0), 0);
    dst_ready_i[3] = 1'b1;
    repeat (4) cyc();
    chk("ch3_drained", lvl(3), 0);

    // ---- held clear on ch3 ----
    clear_i[3] = 1'b1; put(3, 1'b1, 32'hD0);                         // cycle m
    cyc();
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        clear_i[3] = 1'b0; put(3, 1'b0, 32'h0);
        exp_q[3].delete();
      end
      chk("hold_pending", clear_pending_o[3], exp_pend[k-1]);
      if (exp_pend[k-1]) begin
        chk("hold_ready", src_ready_o[3], 1'b0);
        chk("hold_valid", dst_valid_o[3], 1'b0);
      end
      cyc();
    end
    chk("hold_level", lvl(3), 0);

    // ---- reset mid-clear and mid-stream ----
    dst_ready_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1, 1'b1, 32'h200 + i);
      put(0, 1'b1, 32'hF0 + i);
      cyc();
    end
    clear_i[2] = 1'b1;
    cyc();
    clear_i[2] = 1'b0;
    rst_ni = 1'b0; src_valid_i = '0;
    cyc();
    for (int c = 0; c < NC; c++) exp_q[c].delete();
    chk("mrst_src_ready", src_ready_o, 4'hF);
    chk("mrst_dst_valid", dst_valid_o, 4'h0);
    chk("mrst_level", level_o, 16'h0);
    chk("mrst_af", almost_full_o, 4'h0);
    chk("mrst_pending", clear_pending_o, 4'h0);
    rst_ni = 1'b1;
    put(0, 1'b1, 32'hE5); dst_ready_i[0] = 1'b1;
    cyc();
    put(0, 1'b0, 32'h0);
    chk("post_rst_lat", dst_valid_o[0], 1'b0);
    cyc();
    chk("post_rst_valid", dst_valid_o[0], 1'b1);
    chk("post_rst_data", dst_data_o[W-1:0], 32'hE5);
    repeat (3) cyc();

    for (int c = 0; c < NC; c++) chk("leftover", exp_q[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
